// File: rtl/pong_ctrl.sv
// Game-flow controller for the pong graphics block: edge-detects hit/miss/buttons,
// keeps a 2-digit BCD score and the ball count, and freezes the ball between rallies.
module pong_ctrl #(
    parameter int unsigned WAIT_CYCLES = 100_000_000,
    parameter int unsigned BALLS       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn1,
    input  logic [1:0] btn2,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball_cnt,
    output logic [1:0] game_state,
    output logic       timer_busy
);

    typedef enum logic [1:0] {
        S_NEWGAME = 2'd0,
        S_PLAY    = 2'd1,
        S_NEWBALL = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    localparam int unsigned   TW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

    state_t        state_q, state_d;
    logic          gra_still_q, gra_still_d;
    logic [3:0]    dig0_q, dig0_d;
    logic [3:0]    dig1_q, dig1_d;
    logic [1:0]    ball_cnt_q, ball_cnt_d;
    logic          timer_busy_q, timer_busy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          btn_any_q, hit_q, miss_q;

    logic          btn_any_s;
    logic          btn_ev_s;
    logic          hit_ev_s;
    logic          miss_ev_s;
    logic [7:0]    score_inc_s;

    // Two-digit BCD increment; 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
        logic [7:0] r;
        if (d0 >= 4'd9) begin
            if (d1 >= 4'd9) begin
                r = 8'h00;
            end else begin
                r = {d1 + 4'd1, 4'd0};
            end
        end else begin
            r = {d1, d0 + 4'd1};
        end
        return r;
    endfunction

    // Next-state, score, ball-count and hold-off timer computation.
    always_comb begin
        btn_any_s   = (|btn1) | (|btn2);
        btn_ev_s    = btn_any_s & ~btn_any_q;
        hit_ev_s    = hit & ~hit_q;
        miss_ev_s   = miss & ~miss_q;
        score_inc_s = bcd_inc(dig1_q, dig0_q);

        state_d      = state_q;
        dig0_d       = dig0_q;
        dig1_d       = dig1_q;
        ball_cnt_d   = ball_cnt_q;
        timer_d      = timer_q;
        timer_busy_d = timer_busy_q;

        case (state_q)
            S_NEWGAME: begin
                ball_cnt_d = BALLS_INIT;
                if (btn_ev_s) begin
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                    state_d = S_PLAY;
                end else begin
                    state_d = S_NEWGAME;
                end
            end
            S_PLAY: begin
                if (hit_ev_s) begin
                    {dig1_d, dig0_d} = score_inc_s;
                end else begin
                    {dig1_d, dig0_d} = {dig1_q, dig0_q};
                end
                if (miss_ev_s) begin
                    if (ball_cnt_q <= 2'd1) begin
                        ball_cnt_d = 2'd0;
                        state_d    = S_OVER;
                    end else begin
                        ball_cnt_d = ball_cnt_q - 2'd1;
                        state_d    = S_NEWBALL;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_NEWBALL: begin
                // Serving only opens up once the hold-off has expired.
                if (!timer_busy_q && btn_ev_s) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_NEWBALL;
                end
            end
            S_OVER: begin
                if (!timer_busy_q) begin
                    ball_cnt_d = BALLS_INIT;
                    state_d    = S_NEWGAME;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                state_d = S_NEWGAME;
            end
        endcase

        if ((state_d != state_q) && ((state_d == S_NEWBALL) || (state_d == S_OVER))) begin
            timer_d      = TIMER_LOAD;
            timer_busy_d = 1'b1;
        end else if (timer_busy_q) begin
            if (timer_q == '0) begin
                timer_busy_d = 1'b0;
            end else begin
                timer_d = timer_q - TIMER_ONE;
            end
        end else begin
            timer_busy_d = 1'b0;
        end

        gra_still_d = (state_d != S_PLAY);
    end

    // State, outputs and input history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_NEWGAME;
            gra_still_q  <= 1'b1;
            dig0_q       <= 4'd0;
            dig1_q       <= 4'd0;
            ball_cnt_q   <= BALLS_INIT;
            timer_busy_q <= 1'b0;
            timer_q      <= '0;
            btn_any_q    <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gra_still_q  <= gra_still_d;
            dig0_q       <= dig0_d;
            dig1_q       <= dig1_d;
            ball_cnt_q   <= ball_cnt_d;
            timer_busy_q <= timer_busy_d;
            timer_q      <= timer_d;
            btn_any_q    <= btn_any_s;
            hit_q        <= hit;
            miss_q       <= miss;
        end
    end

    assign game_state = state_q;
    assign gra_still  = gra_still_q;
    assign dig0       = dig0_q;
    assign dig1       = dig1_q;
    assign ball_cnt   = ball_cnt_q;
    assign timer_busy = timer_busy_q;

endmodule
